tmr_flop_voter: RTL and testbench
=================================

Name: tmr_flop_voter

Overview:
- Downstream consumer of the triple D-flop outputs (qsr, qt, qjk): the same D input implemented with SR, T and JK flip-flops.
- Produces a registered 2-of-3 majority value and flags which flop disagrees.
- Counts disagreement cycles and escalates persistent single-flop disagreement to a sticky fault, held until software clears it.

Parameters:
- CNT_W, 8, width of the saturating mismatch counter err_count.
- PERSIST, 3, consecutive mismatch cycles by the same flop that declare a fault. Legal range 1 .. 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock, same clock as the upstream flops.
- reset  input  1  asynchronous, active-low reset: 0 resets the block immediately, 1 is normal operation.
- qsr  input  1  output of the SR-based D flop.
- qt  input  1  output of the T-based D flop.
- qjk  input  1  output of the JK-based D flop.
- clear_fault  input  1  synchronous clear of err_count, the FSM and fault_id.
- q_vote  output  1  registered majority of qsr/qt/qjk.
- mismatch  output  1  registered: 1 when the three inputs were not all equal.
- fault_id  output  2  offender code: 0 none, 1 qsr, 2 qt, 3 qjk. Meaningful only while fault=1.
- err_count  output  CNT_W  saturating count of mismatch cycles.
- state  output  2  FSM state: 0 AGREE, 1 SUSPECT, 2 FAULT. Encoding 3 is unused.
- fault  output  1  equals (state==FAULT).

Behaviour:
- Reset (reset=0, asynchronous): q_vote, mismatch, fault_id, err_count, state and fault all go to 0. The internal candidate id and run counter also go to 0.
- Latency: all outputs register the inputs sampled at the same rising edge, i.e. one clock of latency.
- Vote: m = (qsr&qt)|(qt&qjk)|(qsr&qjk). On every edge q_vote <= m, in every state, including FAULT.
- Offender id (combinational):
  - 0 if all three inputs are equal.
  - Otherwise the code of the single input that differs from the other two.
  - With three 1-bit inputs exactly one can differ.
- mismatch <= (id != 0).
- err_count: increments by 1 on each edge with id != 0, saturating at 2^CNT_W-1 (no wrap).
- FSM (evaluated at each edge while clear_fault=0):
  - AGREE:
    - id=0: stay.
    - id!=0: cand <= id, run <= 1. Go to FAULT if PERSIST==1, else to SUSPECT.
  - SUSPECT:
    - id=0: go to AGREE, run <= 0.
    - id==cand: run <= run+1. When run+1 == PERSIST, go to FAULT and fault_id <= cand.
    - id!=0 and id!=cand: cand <= id, run <= 1, stay in SUSPECT.
  - FAULT: sticky regardless of inputs. fault_id held. err_count keeps counting.
- clear_fault=1 at an edge (any state) has priority over everything except reset:
  - state <= AGREE; fault_id, cand, run and err_count <= 0.
  - A mismatch in the same cycle is not counted in err_count or run.
  - q_vote and mismatch still update normally.
- Entering FAULT from AGREE (PERSIST==1) also latches fault_id <= id.
- Reset asserted mid-operation (any state) overrides clear_fault and clock activity. Outputs return to 0 without waiting for a clock edge.
- After reset is released, normal operation resumes at the first rising edge with reset=1.

Test Plan:
- All-agree: reset released; qsr=qt=qjk driven 0,1,1,0 on four edges -> q_vote 0,1,1,0 one cycle later; mismatch=0, err_count=0, state=0 throughout.
- Persistent fault (PERSIST=3): qsr=qjk=1, qt=0 for 3 edges -> q_vote=1, mismatch=1, state 1,1,2, then fault=1, fault_id=2, err_count=3. Inputs then agree for 4 edges -> state stays 2, err_count stays 3.
- Alternating offender: mismatch from qsr, then qjk, then qsr on consecutive edges -> state stays 1, fault=0, err_count=3, no fault declared.
- Glitch recovery: one edge with qjk differing, then agreement -> state 1 then 0, err_count=1, fault=0.
- Clear priority: in FAULT with err_count=5, clear_fault=1 on an edge where qt differs -> state=0, fault_id=0, err_count=0, mismatch=1. Next agreeing edge -> mismatch=0.
- Saturation / async reset: CNT_W=2, six mismatch edges -> err_count stops at 3. Then reset=0 driven between clock edges while in SUSPECT -> every output 0 before the next rising edge.

Source files
------------

// File: rtl/tmr_flop_voter.sv
// Majority voter for three redundant flop outputs, with offender tracking,
// a saturating disagreement counter and a sticky single-flop fault FSM.
module tmr_flop_voter #(
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qsr,
  input  logic             qt,
  input  logic             qjk,
  input  logic             clear_fault,
  output logic             q_vote,
  output logic             mismatch,
  output logic [1:0]       fault_id,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state,
  output logic             fault
);

  typedef enum logic [1:0] {
    AGREE   = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);

  state_t           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [1:0]       fid_q, fid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       id;
  logic             maj;

  assign maj = (qsr & qt) | (qt & qjk) | (qsr & qjk);

  // Code of the single input that disagrees with the other two.
  always_comb begin
    id = 2'd0;
    if ((qsr == qt) && (qt == qjk)) id = 2'd0;
    else if (qt == qjk)             id = 2'd1;
    else if (qsr == qjk)            id = 2'd2;
    else                            id = 2'd3;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    fid_d   = fid_q;
    cnt_d   = cnt_q;
    if (clear_fault) begin
      state_d = AGREE;
      cand_d  = 2'd0;
      run_d   = '0;
      fid_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      if ((id != 2'd0) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
      case (state_q)
        AGREE: begin
          if (id != 2'd0) begin
            cand_d = id;
            run_d  = CNT_ONE;
            if (PERSIST == 1) begin
              state_d = FAULT;
              fid_d   = id;
            end else begin
              state_d = SUSPECT;
            end
          end
        end
        SUSPECT: begin
          if (id == 2'd0) begin
            state_d = AGREE;
            run_d   = '0;
          end else if (id == cand_q) begin
            run_d = run_q + CNT_ONE;
            if ((run_q + CNT_ONE) == PERSIST_C) begin
              state_d = FAULT;
              fid_d   = cand_q;
            end
          end else begin
            cand_d = id;
            run_d  = CNT_ONE;
          end
        end
        FAULT:   ;
        default: state_d = AGREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= AGREE;
      cand_q   <= 2'd0;
      run_q    <= '0;
      fid_q    <= 2'd0;
      cnt_q    <= '0;
      q_vote   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      fid_q    <= fid_d;
      cnt_q    <= cnt_d;
      q_vote   <= maj;
      mismatch <= (id != 2'd0);
    end
  end

  assign state     = state_q;
  assign fault     = (state_q == FAULT);
  assign fault_id  = fid_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_tmr_flop_voter.sv
// Directed bench for tmr_flop_voter: one default instance (CNT_W=8) and one
// narrow-counter instance (CNT_W=2) driven by the same stimulus.
module tb_tmr_flop_voter;

  logic       clk;
  logic       reset;
  logic       qsr, qt, qjk, clear_fault;

  logic       q_vote8, mismatch8, fault8;
  logic [1:0] fault_id8, state8;
  logic [7:0] err_count8;

  logic       q_vote2, mismatch2, fault2;
  logic [1:0] fault_id2, state2;
  logic [1:0] err_count2;

  int tests  = 0;
  int failed = 0;

  tmr_flop_voter #(.CNT_W(8), .PERSIST(3)) dut8 (
    .clk(clk), .reset(reset), .qsr(qsr), .qt(qt), .qjk(qjk),
    .clear_fault(clear_fault), .q_vote(q_vote8), .mismatch(mismatch8),
    .fault_id(fault_id8), .err_count(err_count8), .state(state8), .fault(fault8)
  );

  tmr_flop_voter #(.CNT_W(2), .PERSIST(3)) dut2 (
    .clk(clk), .reset(reset), .qsr(qsr), .qt(qt), .qjk(qjk),
    .clear_fault(clear_fault), .q_vote(q_vote2), .mismatch(mismatch2),
    .fault_id(fault_id2), .err_count(err_count2), .state(state2), .fault(fault2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input int qv, input int mm, input int st,
                      input int ec, input int fi);
    check({tag, " d8.q_vote"},    32'(q_vote8),    qv);
    check({tag, " d8.mismatch"},  32'(mismatch8),  mm);
    check({tag, " d8.state"},     32'(state8),     st);
    check({tag, " d8.fault"},     32'(fault8),     (st == 2) ? 1 : 0);
    check({tag, " d8.err_count"}, 32'(err_count8), ec);
    check({tag, " d8.fault_id"},  32'(fault_id8),  fi);
  endtask

  task automatic chk2(input string tag, input int qv, input int mm, input int st,
                      input int ec, input int fi);
    check({tag, " d2.q_vote"},    32'(q_vote2),    qv);
    check({tag, " d2.mismatch"},  32'(mismatch2),  mm);
    check({tag, " d2.state"},     32'(state2),     st);
    check({tag, " d2.fault"},     32'(fault2),     (st == 2) ? 1 : 0);
    check({tag, " d2.err_count"}, 32'(err_count2), ec);
    check({tag, " d2.fault_id"},  32'(fault_id2),  fi);
  endtask

  // Driver: apply inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic drive(input logic a, input logic b, input logic c, input logic clr);
    @(negedge clk);
    qsr = a; qt = b; qjk = c; clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; qsr = 1'b0; qt = 1'b0; qjk = 1'b0; clear_fault = 1'b0;
    #3;
    chk8("reset_pre_edge", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk8("reset_held", 0, 0, 0, 0, 0);
    chk2("reset_held", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // All inputs agree
    drive(0, 0, 0, 0); chk8("agree0", 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0); chk8("agree1", 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0); chk8("agree2", 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0); chk8("agree3", 0, 0, 0, 0, 0);

    // qt persistently wrong: SUSPECT, SUSPECT, FAULT
    drive(1, 0, 1, 0); chk8("pers1", 1, 1, 1, 1, 0);
    drive(1, 0, 1, 0); chk8("pers2", 1, 1, 1, 2, 0);
    drive(1, 0, 1, 0); chk8("pers3", 1, 1, 2, 3, 2); chk2("pers3", 1, 1, 2, 3, 2);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0); chk8("sticky", 0, 0, 2, 3, 2);
    end

    // Keep counting in FAULT, then clear on a mismatching edge
    drive(1, 1, 0, 0); chk8("fault_cnt4", 1, 1, 2, 4, 2); chk2("fault_sat", 1, 1, 2, 3, 2);
    drive(1, 1, 0, 0); chk8("fault_cnt5", 1, 1, 2, 5, 2);
    drive(0, 1, 0, 1); chk8("clear_prio", 0, 1, 0, 0, 0); chk2("clear_prio", 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0); chk8("after_clear", 1, 0, 0, 0, 0);

    // Offender changes every edge: never a fault
    drive(0, 1, 1, 0); chk8("alt1", 1, 1, 1, 1, 0);
    drive(1, 1, 0, 0); chk8("alt2", 1, 1, 1, 2, 0);
    drive(0, 1, 1, 0); chk8("alt3", 1, 1, 1, 3, 0);
    drive(0, 0, 0, 1); chk8("clear_idle", 0, 0, 0, 0, 0);

    // Single-edge glitch then recovery
    drive(1, 1, 0, 0); chk8("glitch", 1, 1, 1, 1, 0);
    drive(1, 1, 1, 0); chk8("recover", 1, 0, 0, 1, 0);
    drive(0, 0, 0, 1); chk2("clear2", 0, 0, 0, 0, 0);

    // Narrow counter saturates at 3 while the offender alternates
    for (int i = 1; i <= 6; i++) begin
      if (i % 2 == 1) drive(0, 1, 1, 0);
      else            drive(1, 1, 0, 0);
      chk2("sat", 1, 1, 1, (i > 3) ? 3 : i, 0);
      chk8("sat", 1, 1, 1, i, 0);
    end

    // Asynchronous reset between edges while in SUSPECT
    #2;
    reset = 1'b0;
    #1;
    chk8("async_reset", 0, 0, 0, 0, 0);
    chk2("async_reset", 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1);
    chk8("reset_over_clear", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 1, 0); chk8("post_reset", 1, 1, 1, 1, 0); chk2("post_reset", 1, 1, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
